// File: rtl/comm_rx_decoder.sv
// Receive-side packet decoder for the two-board link: START, DIR and SEED packets
// from the UART byte stream, plus a link watchdog fed only by DIR bytes.
module comm_rx_decoder #(
   parameter int BYTE_TIMEOUT = 75_000,
   parameter int LINK_TIMEOUT = 75_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       watch_en,
   output logic [1:0] dir2,
   output logic       rcvdir,
   output logic [4:0] seed_x_out,
   output logic [4:0] seed_y_out,
   output logic       seed_valid,
   output logic       start_game,
   output logic       frame_err,
   output logic       con_error
);

   // state      | meaning
   // S_IDLE     | waiting for a header byte (START, DIR or SEED)
   // S_SEED_X   | SEED header seen, next byte is X
   // S_SEED_Y   | X held, next byte is Y
   // S_SEED_CHK | X and Y held, next byte is the checksum
   typedef enum logic [1:0] {
      S_IDLE,
      S_SEED_X,
      S_SEED_Y,
      S_SEED_CHK
   } state_t;

   localparam int BW = $clog2(BYTE_TIMEOUT + 1);
   localparam int LW = $clog2(LINK_TIMEOUT + 1);
   localparam logic [BW-1:0] BYTE_TO_C = BW'(BYTE_TIMEOUT);
   localparam logic [LW-1:0] LINK_TO_C = LW'(LINK_TIMEOUT);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BW-1:0]   r_byte_cnt;
   logic [LW-1:0]   r_wd_cnt;
   logic [LW-1:0]   w_wd_nxt;
   logic [7:0]      r_hold_x;
   logic [7:0]      r_hold_y;
   logic [1:0]      r_dir2;
   logic [4:0]      r_seed_x;
   logic [4:0]      r_seed_y;
   logic            r_rcvdir;
   logic            r_seed_valid;
   logic            r_start_game;
   logic            r_frame_err;
   logic            r_con_error;

   logic            w_byte_to;
   logic            w_start;
   logic            w_dir_acc;
   logic            w_seed_ok;
   logic            w_frame_err;
   logic            w_ld_x;
   logic            w_ld_y;
   logic            w_chk_ok;

   assign w_byte_to = (r_byte_cnt == BYTE_TO_C);
   assign w_chk_ok  = (r_hold_x[7:5] == 3'b000) && (r_hold_y[7:5] == 3'b000) &&
                      (rx_data == (8'hC5 ^ r_hold_x ^ r_hold_y));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // A byte arriving in the same cycle as the timeout takes priority over it.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_dir_acc   = 1'b0;
      w_seed_ok   = 1'b0;
      w_frame_err = 1'b0;
      w_ld_x      = 1'b0;
      w_ld_y      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == 8'h55)                 w_start = 1'b1;
               else if (rx_data[7:2] == 6'b101000)  w_dir_acc = 1'b1;
               else if (rx_data == 8'hC5)           w_state_nxt = S_SEED_X;
            end
         end
         S_SEED_X: begin
            if (rx_valid) begin
               w_ld_x      = 1'b1;
               w_state_nxt = S_SEED_Y;
            end else if (w_byte_to) begin
               w_frame_err = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_SEED_Y: begin
            if (rx_valid) begin
               w_ld_y      = 1'b1;
               w_state_nxt = S_SEED_CHK;
            end else if (w_byte_to) begin
               w_frame_err = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_SEED_CHK: begin
            if (rx_valid) begin
               w_seed_ok   = w_chk_ok;
               w_frame_err = ~w_chk_ok;
               w_state_nxt = S_IDLE;
            end else if (w_byte_to) begin
               w_frame_err = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_hold_x   <= '0;
         r_hold_y   <= '0;
      end else begin
         if (r_state == S_IDLE || rx_valid || w_byte_to) r_byte_cnt <= '0;
         else                                            r_byte_cnt <= r_byte_cnt + BW'(1);
         if (r_state == S_IDLE) begin
            r_hold_x <= '0;
            r_hold_y <= '0;
         end else begin
            if (w_ld_x) r_hold_x <= rx_data;
            if (w_ld_y) r_hold_y <= rx_data;
         end
      end
   end

   // Watchdog saturates, so con_error is simply "counter at limit".
   always_comb begin
      w_wd_nxt = r_wd_cnt;
      if (!watch_en || w_dir_acc)   w_wd_nxt = '0;
      else if (r_wd_cnt != LINK_TO_C) w_wd_nxt = r_wd_cnt + LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt     <= '0;
         r_con_error  <= 1'b0;
         r_dir2       <= 2'b00;
         r_seed_x     <= '0;
         r_seed_y     <= '0;
         r_rcvdir     <= 1'b0;
         r_seed_valid <= 1'b0;
         r_start_game <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_wd_cnt     <= w_wd_nxt;
         r_con_error  <= (w_wd_nxt == LINK_TO_C);
         r_rcvdir     <= w_dir_acc;
         r_seed_valid <= w_seed_ok;
         r_start_game <= w_start;
         r_frame_err  <= w_frame_err;
         if (w_dir_acc) r_dir2 <= rx_data[1:0];
         if (w_seed_ok) begin
            r_seed_x <= r_hold_x[4:0];
            r_seed_y <= r_hold_y[4:0];
         end
      end
   end

   assign dir2       = r_dir2;
   assign rcvdir     = r_rcvdir;
   assign seed_x_out = r_seed_x;
   assign seed_y_out = r_seed_y;
   assign seed_valid = r_seed_valid;
   assign start_game = r_start_game;
   assign frame_err  = r_frame_err;
   assign con_error  = r_con_error;

endmodule

// File: doc/comm_rx_decoder.md
# comm_rx_decoder

Receive-side packet decoder for the two-board link. Consumes the byte stream from the UART receiver and reconstructs the opponent's messages: direction updates, seed transfers and game start. Drives `dir2`, `rcvdir`, the ingoing seed and `start_game` toward `move`, `generate_point` and `mode_control`. Flags link loss on `con_error`.

## Interface
Parameters:
- `BYTE_TIMEOUT`, default 75_000: maximum gap, in clk cycles, between bytes inside a seed packet (1 ms at 75 MHz).
- `LINK_TIMEOUT`, default 75_000_000: maximum gap, in clk cycles, between valid DIR bytes while the watchdog is enabled (1 s).

Ports:
- `clk`  in  1: 75 MHz system clock. One clock domain only.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_data`  in  8: received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1: single-cycle strobe from the UART receiver, one per byte.
- `watch_en`  in  1: enables the link watchdog. High while a game is running.
- `dir2`  out  `direction`: last opponent direction received; held between updates.
- `rcvdir`  out  1: single-cycle pulse when `dir2` is updated.
- `seed_x_out`, `seed_y_out`  out  5 each: last accepted seed.
- `seed_valid`  out  1: single-cycle pulse when a new seed is accepted.
- `start_game`  out  1: single-cycle pulse on a START byte.
- `frame_err`  out  1: single-cycle pulse when a packet is dropped.
- `con_error`  out  1: level; link lost.

## Operation
Packet formats:
- START: one byte, 0x55.
- DIR: one byte, 0b101000dd (0xA0..0xA3). `dd` is the `direction` encoding.
- SEED: four bytes: 0xC5, X, Y, CHK.
  - X and Y must have bits [7:5] = 0.
  - CHK must equal 0xC5 ^ X ^ Y.

State machine: IDLE, SEED_X, SEED_Y, SEED_CHK.
- IDLE:
  - 0x55 → pulse `start_game`.
  - 0xA0..0xA3 → load `dir2`, pulse `rcvdir`.
  - 0xC5 → go to SEED_X.
  - Any other byte → discarded silently; no `frame_err`.
- SEED_X: latch X into a holding register, go to SEED_Y.
- SEED_Y: latch Y, go to SEED_CHK.
- SEED_CHK: on the checksum byte:
  - If X[7:5] = 0, Y[7:5] = 0 and CHK matches: copy X[4:0] and Y[4:0] to the outputs and pulse `seed_valid`.
  - Otherwise: pulse `frame_err` and leave the outputs unchanged.
  - Return to IDLE in either case.
- Inside SEED_*, every byte is payload, including 0x55, 0xA0..0xA3 and 0xC5. There is no resync on header values; the checksum catches misalignment.
- Byte timeout: a counter runs in every SEED_* state and clears on each `rx_valid`. When it reaches `BYTE_TIMEOUT`, pulse `frame_err` and return to IDLE. Holding registers are discarded.

Watchdog:
- A counter clears on every accepted DIR byte and whenever `watch_en` = 0.
- While `watch_en` = 1 it increments each cycle and saturates at `LINK_TIMEOUT`.
- `con_error` is set when the counter reaches `LINK_TIMEOUT`.
- `con_error` clears on the next accepted DIR byte or when `watch_en` = 0.
- START and SEED bytes do not feed the watchdog.

Counter widths are `$clog2(param+1)`; neither counter ever wraps.

## Timing
- Reset values:
  - `dir2` = 2'b00.
  - `seed_x_out` = 0, `seed_y_out` = 0.
  - `rcvdir`, `seed_valid`, `start_game`, `frame_err`, `con_error` all 0.
  - State = IDLE; both counters = 0.
- All outputs are registered. Every pulse is asserted in the cycle after the `rx_valid` that caused it, and lasts exactly one cycle.
- `dir2` and the seed outputs change in the same cycle as their pulse.
- Byte timeout: `frame_err` is asserted in the cycle after the counter reaches `BYTE_TIMEOUT`.
- Collision: if `rx_valid` arrives in the same cycle the counter would expire, the byte wins. It is processed and the counter is cleared.
- DIR accepted while `con_error` = 1: `con_error` falls in the same cycle `rcvdir` rises.
- `rst` asserted mid-packet: immediate return to IDLE; all outputs go to their reset values with no pulse.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss.

## Test plan
- Reset, then bytes 0x55 and 0xA2 → `start_game` pulses one cycle; then `rcvdir` pulses with `dir2` = 2'b10; no `frame_err`.
- SEED 0xC5, 0x0C, 0x13, 0xDA (0xC5^0x0C^0x13) → `seed_valid` pulse; `seed_x_out` = 12, `seed_y_out` = 19.
- SEED 0xC5, 0x0C, 0x13, 0xDB → `frame_err` pulse, no `seed_valid`, seed outputs unchanged; a following 0xA1 still yields `rcvdir`.
- SEED 0xC5, 0x25, … (X bit 5 set), and separately 0xC5 then silence for `BYTE_TIMEOUT` cycles → `frame_err` in both cases; state back to IDLE; next 0x55 gives `start_game`.
- `watch_en` = 1 with no DIR bytes (`LINK_TIMEOUT` set to 100 in the bench) → `con_error` rises at cycle 100 and holds; an 0xA3 clears it with `rcvdir`; dropping `watch_en` also clears it.
- Assert `rst` between 0xC5 and X → outputs at reset values; a subsequent full valid SEED packet decodes correctly.
